// File: rtl/ram_stream_reader_if.sv
// Bundle of the ram_stream_reader control, RAM read-port and stream signals.
// The slave modport is the reader's view; master is the view of whoever drives it.
interface ram_stream_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic                  start_i;
  logic [ADDR_WIDTH-1:0] base_addr_i;
  logic [ADDR_WIDTH:0]   len_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  ram_rd_o;
  logic [ADDR_WIDTH-1:0] ram_rd_addr_o;
  logic [DATA_WIDTH-1:0] ram_rd_data_i;
  logic [DATA_WIDTH-1:0] tdata_o;
  logic                  tvalid_o;
  logic                  tlast_o;
  logic                  tready_i;

  modport slave (
    input  start_i, base_addr_i, len_i, ram_rd_data_i, tready_i,
    output busy_o, done_o, ram_rd_o, ram_rd_addr_o, tdata_o, tvalid_o, tlast_o
  );

  modport master (
    output start_i, base_addr_i, len_i, ram_rd_data_i, tready_i,
    input  busy_o, done_o, ram_rd_o, ram_rd_addr_o, tdata_o, tvalid_o, tlast_o
  );
endinterface

// File: rtl/ram_stream_reader.sv
// Streams a burst of RAM words out as a valid/ready stream; first beat two edges after the first read.
// Keeps at most two words buffered or in flight, so tready_i low stalls reads after two words.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ram_stream_reader_if.slave  bus
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_dat_q, out_dat_d;
  logic                  out_last_q, out_last_d;
  logic                  skid_vld_q, skid_vld_d;
  logic [DATA_WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic                  skid_last_q, skid_last_d;
  logic                  done_q, done_d;

  logic       pop;
  logic       rd_issue;
  logic [2:0] pending;

  // Words already buffered plus the read whose data arrives on the next edge.
  assign pop      = out_vld_q & bus.tready_i;
  assign pending  = 3'(out_vld_q) + 3'(skid_vld_q) + 3'(inflight_q);
  assign rd_issue = (state_q == READ) && (pending < (3'd2 + 3'(pop)));

  assign bus.ram_rd_o      = rd_issue;
  assign bus.ram_rd_addr_o = rd_ptr_q;
  assign bus.busy_o        = (state_q != IDLE);
  assign bus.done_o        = done_q;
  assign bus.tdata_o       = out_dat_q;
  assign bus.tvalid_o      = out_vld_q;
  assign bus.tlast_o       = out_last_q;

  always_comb begin
    state_d         = state_q;
    rd_ptr_d        = rd_ptr_q;
    issue_cnt_d     = issue_cnt_q;
    beat_cnt_d      = beat_cnt_q;
    done_d          = 1'b0;
    inflight_d      = rd_issue;
    inflight_last_d = rd_issue && (issue_cnt_q == CW'(1));

    if (pop) begin
      beat_cnt_d = beat_cnt_q - CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = READ;
            rd_ptr_d    = bus.base_addr_i;
            issue_cnt_d = bus.len_i;
            beat_cnt_d  = bus.len_i;
          end
        end
      end
      READ: begin
        if (rd_issue) begin
          rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
          issue_cnt_d = issue_cnt_q - CW'(1);
          if (issue_cnt_q == CW'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && (beat_cnt_q == CW'(1))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Two-entry buffer: the output register plus a skid entry behind it.
  always_comb begin
    out_vld_d   = out_vld_q;
    out_dat_d   = out_dat_q;
    out_last_d  = out_last_q;
    skid_vld_d  = skid_vld_q;
    skid_dat_d  = skid_dat_q;
    skid_last_d = skid_last_q;

    if (!out_vld_q || pop) begin
      if (skid_vld_q) begin
        out_vld_d   = 1'b1;
        out_dat_d   = skid_dat_q;
        out_last_d  = skid_last_q;
        skid_vld_d  = inflight_q;
        skid_dat_d  = bus.ram_rd_data_i;
        skid_last_d = inflight_last_q;
      end else if (inflight_q) begin
        out_vld_d  = 1'b1;
        out_dat_d  = bus.ram_rd_data_i;
        out_last_d = inflight_last_q;
      end else begin
        out_vld_d  = 1'b0;
        out_last_d = 1'b0;
      end
    end else if (inflight_q) begin
      skid_vld_d  = 1'b1;
      skid_dat_d  = bus.ram_rd_data_i;
      skid_last_d = inflight_last_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      rd_ptr_q        <= '0;
      issue_cnt_q     <= '0;
      beat_cnt_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      out_vld_q       <= 1'b0;
      out_dat_q       <= '0;
      out_last_q      <= 1'b0;
      skid_vld_q      <= 1'b0;
      skid_dat_q      <= '0;
      skid_last_q     <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_ptr_q        <= rd_ptr_d;
      issue_cnt_q     <= issue_cnt_d;
      beat_cnt_q      <= beat_cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      out_vld_q       <= out_vld_d;
      out_dat_q       <= out_dat_d;
      out_last_q      <= out_last_d;
      skid_vld_q      <= skid_vld_d;
      skid_dat_q      <= skid_dat_d;
      skid_last_q     <= skid_last_d;
      done_q          <= done_d;
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: a RAM model plus a burst-level reference model
// (expected addresses and words from base/len arithmetic) with random backpressure.
module tb_ram_stream_reader;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [7:0] mem [32];
  logic [7:0] ram_q;

  ram_stream_reader_if bus ();

  ram_stream_reader dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM: data appears the cycle after a sampled read strobe.
  always @(posedge clk) begin
    if (bus.ram_rd_o) ram_q <= mem[bus.ram_rd_addr_o];
  end
  assign bus.ram_rd_data_i = ram_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Runs one burst and compares every cycle against the expected stream.
  task automatic run_burst(input int base, input int len, input int pct,
                           input bit chk_lat, input int inj_cyc);
    int   issued;
    int   acc;
    int   c;
    bit   fin;
    bit   pop;
    bit   prev_stall;
    logic [7:0] prev_dat;
    logic prev_last;
    issued = 0; acc = 0; c = 0; fin = 0; prev_stall = 0;
    prev_dat = '0; prev_last = 1'b0;

    @(negedge clk);
    bus.start_i     = 1'b1;
    bus.base_addr_i = 5'(base);
    bus.len_i       = 6'(len);
    bus.tready_i    = 1'b0;
    @(posedge clk);

    while (!fin && c < 400) begin
      @(negedge clk);
      c++;
      bus.start_i = (c == inj_cyc);
      if (c == inj_cyc) begin
        bus.base_addr_i = 5'd20;
        bus.len_i       = 6'd5;
      end
      bus.tready_i = ($urandom_range(99) < pct);
      #1;
      pop = bus.tvalid_o && bus.tready_i;

      if (c == 1) begin
        check("busy_start", bus.busy_o, (len > 0));
        if (len > 0) check("rd_start", bus.ram_rd_o, 1);
      end
      if (bus.ram_rd_o) begin
        check("rd_addr", bus.ram_rd_addr_o, (base + issued) % 32);
        check("rd_extra", (issued < len), 1);
        check("rd_window", ((issued - acc - int'(pop)) < 2), 1);
        issued++;
      end
      if (prev_stall) begin
        check("stall_vld", bus.tvalid_o, 1);
        check("stall_dat", bus.tdata_o, prev_dat);
        check("stall_last", bus.tlast_o, prev_last);
      end
      if (chk_lat) begin
        if (c <= len + 1) check("rd_seq", bus.ram_rd_o, (c <= len));
        if (c <= len + 2) check("no_bubble", bus.tvalid_o, (c >= 3));
        if (c == len + 3) check("done_lat", bus.done_o, 1);
      end
      if (pop) begin
        check("beat_extra", (acc < len), 1);
        check("beat_dat", bus.tdata_o, mem[(base + acc) % 32]);
        check("beat_last", bus.tlast_o, (acc == len - 1));
        acc++;
      end
      if (bus.done_o) begin
        check("done_beats", acc, len);
        check("done_busy", bus.busy_o, 0);
        fin = 1;
      end
      prev_stall = bus.tvalid_o && !bus.tready_i;
      prev_dat   = bus.tdata_o;
      prev_last  = bus.tlast_o;
    end
    bus.start_i = 1'b0;
    if (!fin) check("timeout", 0, 1);

    @(negedge clk);
    #1;
    check("done_pulse", bus.done_o, 0);
    check("idle_busy", bus.busy_o, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.busy_o, 0);
    check({tag, "_done"}, bus.done_o, 0);
    check({tag, "_rd"}, bus.ram_rd_o, 0);
    check({tag, "_addr"}, bus.ram_rd_addr_o, 0);
    check({tag, "_vld"}, bus.tvalid_o, 0);
    check({tag, "_last"}, bus.tlast_o, 0);
    check({tag, "_dat"}, bus.tdata_o, 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    ram_q = '0;
    for (int a = 0; a < 32; a++) mem[a] = 8'(a + 16);
    bus.start_i     = 1'b0;
    bus.base_addr_i = '0;
    bus.len_i       = '0;
    bus.tready_i    = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_burst(3, 4, 100, 1, 0);
    run_burst(30, 4, 100, 1, 0);
    run_burst(0, 8, 50, 0, 0);
    run_burst(0, 0, 100, 0, 0);
    run_burst(0, 6, 100, 0, 3);

    // Abort a stalled burst mid-flight.
    @(negedge clk);
    bus.start_i     = 1'b1;
    bus.base_addr_i = 5'd0;
    bus.len_i       = 6'd8;
    bus.tready_i    = 1'b0;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("pre_rst_vld", bus.tvalid_o, 1);
    #1 rst = 1'b1;
    #1;
    check_all_zero("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_burst(5, 2, 100, 1, 0);

    for (int a = 0; a < 32; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      run_burst($urandom_range(31), $urandom_range(40, 1), $urandom_range(100, 20), 0, 0);
    end
    run_burst(7, 63, 70, 0, 0);
    run_burst(12, 10, 100, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 DATA_WIDTH, 8, width of RAM word and stream data.
REQ-002 ADDR_WIDTH, 5, width of RAM read address.
REQ-003 clk_i  input  1  single clock for all logic.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 start_i  input  1  request a burst; sampled only in IDLE.
REQ-006 base_addr_i  input  ADDR_WIDTH  first RAM address of burst; sampled with start_i.
REQ-007 len_i  input  ADDR_WIDTH+1  number of words in burst; sampled with start_i.
REQ-008 busy_o  output  1  burst in progress.
REQ-009 done_o  output  1  one-cycle pulse at burst completion.
REQ-010 ram_rd_o  output  1  read strobe to the dual-port RAM read port (rd_i).
REQ-011 ram_rd_addr_o  output  ADDR_WIDTH  read address to the RAM (rd_addr_i).
REQ-012 ram_rd_data_i  input  DATA_WIDTH  RAM read data (rd_data_o): registered, valid the cycle after the edge that sampled ram_rd_o=1, held while ram_rd_o=0.
REQ-013 tdata_o  output  DATA_WIDTH  stream data.
REQ-014 tvalid_o  output  1  stream data valid.
REQ-015 tlast_o  output  1  marks the final word of a burst; qualified by tvalid_o.
REQ-016 tready_i  input  1  downstream accept; a word transfers on an edge with tvalid_o=1 and tready_i=1.

Function
REQ-017 FSM states: IDLE, READ, DRAIN; the FSM occupies exactly one state at a time.
REQ-018 IDLE: start_i=1 with len_i>0 -> READ; latch base_addr_i as read pointer, len_i as issue and beat counters.
REQ-019 IDLE: start_i=1 with len_i=0 -> stay IDLE; done_o=1 in the next cycle; no RAM read, no stream beat.
REQ-020 start_i outside IDLE is ignored; base_addr_i and len_i are not re-sampled.
REQ-021 READ: ram_rd_o=1 in a cycle only when (buffered words + in-flight reads - words popped this cycle) < 2; ram_rd_addr_o = read pointer.
REQ-022 Each issued read increments the read pointer modulo 2^ADDR_WIDTH (wrap 2^ADDR_WIDTH-1 -> 0) and decrements the issue counter.
REQ-023 READ -> DRAIN on the edge issuing the last read; ram_rd_o=0 in DRAIN and IDLE.
REQ-024 Read data is captured into a 2-entry output buffer on the edge one cycle after the read's sampling edge; it is never dropped or duplicated.
REQ-025 The buffer outputs words in issue order; tdata_o, tvalid_o and tlast_o come from registers; no combinational path from tready_i to tvalid_o or tdata_o.
REQ-026 tdata_o and tlast_o remain stable while tvalid_o=1 and tready_i=0.
REQ-027 tlast_o=1 only on beat number len (beat counter = 1).
REQ-028 DRAIN -> IDLE on the edge transferring the tlast_o beat; done_o=1 in the following cycle only.
REQ-029 busy_o=1 in READ and DRAIN, 0 in IDLE.
REQ-030 With tready_i held 1: start edge E0; ram_rd_o=1 from cycle E0+1; first tvalid_o=1 in the cycle after edge E0+2; one word per cycle thereafter; no bubbles.
REQ-031 With tready_i=0 the block issues at most 2 reads beyond the last accepted word and then stalls ram_rd_o=0.
REQ-032 len_i up to 2^(ADDR_WIDTH+1)-1 is legal; addresses keep wrapping, reading words again.

Reset
REQ-033 rst_i=1 asynchronously forces IDLE, clears buffer, in-flight flag and counters: busy_o=0, done_o=0, ram_rd_o=0, ram_rd_addr_o=0, tvalid_o=0, tlast_o=0, tdata_o=0.
REQ-034 Reset mid-burst aborts it; RAM data returning after reset release is discarded; no done_o pulse for the aborted burst.

Verification
REQ-035 RAM preloaded with mem[a]=a+0x10; base=3, len=4, tready_i=1 -> beats 0x13,0x14,0x15,0x16, tlast_o on 0x16, first tvalid_o 3 cycles after start edge, done_o one cycle after last beat.
REQ-036 base=30, len=4, ADDR_WIDTH=5 -> ram_rd_addr_o sequence 30,31,0,1; beats 0x2E,0x2F,0x10,0x11.
REQ-037 base=0, len=8, tready_i random 50% -> 8 beats 0x10..0x17 in order, no loss or duplication, ram_rd_o never asserted with 2 words outstanding; tdata_o stable while stalled.
REQ-038 len=0 start -> done_o pulse next cycle, ram_rd_o and tvalid_o stay 0, busy_o stays 0.
REQ-039 Second start_i pulse with base=20 during a burst base=0 len=6 -> ignored; output 0x10..0x15 only.
REQ-040 rst_i asserted on cycle 4 of a len=8 burst with tready_i=0 -> all outputs 0 immediately; next burst base=5 len=2 yields exactly 0x15,0x16.
